// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_scan_ctrl_pkg;

  typedef enum logic [0:0] {StGuard, StShow} state_e;

  localparam int unsigned DIG_W = 4;
  // Wide enough for the largest supported digit count; callers slice it down.
  localparam logic [7:0] AN_OFF = 8'hFF;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg_scan_if.sv
// Display-side bundle: load/data/config from the host, nibble/anode/frame strobe back.
interface seg_scan_if
  import seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4
);

  logic                        load;
  logic [DIG_W*NUM_DIGITS-1:0] data_in;
  logic [NUM_DIGITS-1:0]       digit_en;
  logic                        lz_blank;
  logic [DIG_W-1:0]            nibble;
  logic [NUM_DIGITS-1:0]       an;
  logic                        frame_done;

  modport master (
    output load, data_in, digit_en, lz_blank,
    input  nibble, an, frame_done
  );

  modport slave (
    input  load, data_in, digit_en, lz_blank,
    output nibble, an, frame_done
  );

endinterface

// File: rtl/seg_scan_tick.sv
// Slot prescaler: free-running 0..REFRESH_DIV-1 counter, tick on the last count.
module seg_scan_tick
  import seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = idx_w(REFRESH_DIV);

  logic [CW-1:0] div_cnt_q, div_cnt_d;

  assign tick = (div_cnt_q == CW'(REFRESH_DIV - 1));

  always_comb begin
    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) div_cnt_q <= '0;
    else     div_cnt_q <= div_cnt_d;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed N-digit scan controller with guard slots, blanking and
// frame-aligned double-buffered display data. The segment decoder lives outside.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input logic      clk,
  input logic      rst,
  seg_scan_if.slave bus
);

  localparam int unsigned IW = idx_w(NUM_DIGITS);
  localparam int unsigned GW = idx_w(BLANK_CYCLES + 1);
  localparam int unsigned DW = DIG_W * NUM_DIGITS;
  localparam state_e SLOT_START = (BLANK_CYCLES == 0) ? StShow : StGuard;

  logic tick;

  seg_scan_tick #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [GW-1:0]   guard_q, guard_d;
  logic [DW-1:0]   shadow_q, shadow_d;
  logic [DW-1:0]   active_q, active_d;
  logic            pending_q, pending_d;
  logic            frame_done_q;
  logic            frame_end;
  logic [NUM_DIGITS-1:0] blank;
  logic [NUM_DIGITS-1:0] an_d;
  logic            zero_run;

  assign frame_end = tick && (idx_q == IW'(NUM_DIGITS - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    guard_d = guard_q;
    if (tick) begin
      idx_d   = frame_end ? '0 : idx_q + 1'b1;
      guard_d = '0;
      state_d = SLOT_START;
    end else if (state_q == StGuard) begin
      guard_d = guard_q + 1'b1;
      if (guard_q == GW'(BLANK_CYCLES - 1)) state_d = StShow;
    end
  end

  // A load on the frame-boundary edge bypasses the shadow so it shows this frame.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (bus.load) begin
      shadow_d  = bus.data_in;
      pending_d = 1'b1;
    end
    if (frame_end) begin
      if (bus.load) begin
        active_d  = bus.data_in;
        pending_d = 1'b0;
      end else if (pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
    end
  end

  // Scan from the top digit down so zero_run means "this and all higher nibbles are 0".
  always_comb begin
    zero_run = 1'b1;
    blank    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (active_q[i*DIG_W +: DIG_W] == '0);
      blank[i] = !bus.digit_en[i] || (bus.lz_blank && (i > 0) && zero_run);
    end
  end

  always_comb begin
    an_d = AN_OFF[NUM_DIGITS-1:0];
    if (state_q == StShow && !blank[idx_q]) an_d[idx_q] = 1'b0;
  end

  assign bus.an         = an_d;
  assign bus.nibble     = active_q[idx_q*DIG_W +: DIG_W];
  assign bus.frame_done = frame_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SLOT_START;
      idx_q        <= '0;
      guard_q      <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      guard_q      <= guard_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed scoreboard bench for seg_scan_ctrl (4 digits, 8-clock slots, 2 guard clocks).
module tb_seg_scan_ctrl;
  import seg_scan_ctrl_pkg::*;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] nib;
    logic       fd;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   cyc;
  exp_t exp_q[$];

  seg_scan_if #(.NUM_DIGITS(4)) bus ();

  seg_scan_ctrl #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, want);
    end
  endtask

  // Expected waveform of one full frame, given what the frame should display.
  task automatic push_frame(input logic [15:0] val, input logic [3:0] en, input logic lz,
                            input logic first_fd);
    exp_t e;
    logic blank;
    for (int d = 0; d < 4; d++) begin
      blank = !en[d] || (lz && d > 0 && ((val >> (4 * d)) == 16'h0));
      for (int p = 0; p < 8; p++) begin
        e.an  = (p < 2 || blank) ? 4'hF : ~(4'b0001 << d);
        e.nib = val[4*d +: 4];
        e.fd  = (d == 0 && p == 0) ? first_fd : 1'b0;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic check_one();
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL queue_empty cyc=%0d observed=empty expected=entry", cyc);
    end else begin
      e = exp_q.pop_front();
      chk("an", 32'(bus.an), 32'(e.an));
      chk("nibble", 32'(bus.nibble), 32'(e.nib));
      chk("frame_done", 32'(bus.frame_done), 32'(e.fd));
    end
    cyc++;
  endtask

  task automatic drain(input int n);
    repeat (n) begin
      check_one();
      @(negedge clk);
    end
  endtask

  task automatic pulse_load(input logic [15:0] v);
    bus.data_in = v;
    bus.load    = 1'b1;
    check_one();
    @(negedge clk);
    bus.load    = 1'b0;
  endtask

  initial begin
    clk          = 1'b0;
    rst          = 1'b1;
    total        = 0;
    bad          = 0;
    cyc          = 0;
    bus.load     = 1'b0;
    bus.data_in  = 16'h0;
    bus.digit_en = 4'hF;
    bus.lz_blank = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    chk("rst_an", 32'(bus.an), 32'hF);
    chk("rst_nibble", 32'(bus.nibble), 32'h0);
    chk("rst_frame_done", 32'(bus.frame_done), 32'h0);
    chk("rst_idx", 32'(dut.idx_q), 32'h0);
    chk("rst_state", 32'(dut.state_q), 32'(StGuard));
    chk("rst_pending", 32'(dut.pending_q), 32'h0);
    rst = 1'b0;

    // Idle frame of zeros; a mid-frame load must not disturb it.
    push_frame(16'h0000, 4'hF, 1'b0, 1'b0);
    drain(10);
    pulse_load(16'h1234);
    drain(21);

    push_frame(16'h1234, 4'hF, 1'b0, 1'b1);
    drain(5);
    pulse_load(16'h0070);
    drain(26);

    bus.lz_blank = 1'b1;
    push_frame(16'h0070, 4'hF, 1'b1, 1'b1);
    drain(8);
    pulse_load(16'h0000);
    drain(23);

    push_frame(16'h0000, 4'hF, 1'b1, 1'b1);
    drain(3);
    pulse_load(16'h5678);
    drain(28);

    bus.lz_blank = 1'b0;
    bus.digit_en = 4'b1010;
    push_frame(16'h5678, 4'b1010, 1'b0, 1'b1);
    drain(31);
    pulse_load(16'hABCD);

    bus.digit_en = 4'hF;
    chk("pending_boundary", 32'(dut.pending_q), 32'h0);
    push_frame(16'hABCD, 4'hF, 1'b0, 1'b1);
    drain(3);
    pulse_load(16'h1111);
    drain(16);
    pulse_load(16'h2222);
    drain(11);

    push_frame(16'h2222, 4'hF, 1'b0, 1'b1);
    drain(32);

    // Reset during digit 2's lit phase.
    push_frame(16'h2222, 4'hF, 1'b0, 1'b1);
    drain(20);
    chk("pre_rst_an", 32'(bus.an), 32'hB);
    rst = 1'b1;
    check_one();
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    cyc = 0;
    chk("mid_rst_an", 32'(bus.an), 32'hF);
    chk("mid_rst_idx", 32'(dut.idx_q), 32'h0);
    chk("mid_rst_state", 32'(dut.state_q), 32'(StGuard));
    chk("mid_rst_active", 32'(dut.active_q), 32'h0);
    chk("mid_rst_shadow", 32'(dut.shadow_q), 32'h0);
    push_frame(16'h0000, 4'hF, 1'b0, 1'b0);
    push_frame(16'h0000, 4'hF, 1'b0, 1'b1);
    drain(64);

    chk("queue_left", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
